replay_ctrl: RTL

Parametrised record/playback controller for the robot-arm UART path. Received bytes are written into a dual-port RAM partitioned into `NUM_FRAMES` frames of `FRAME_LEN` bytes. Stored frames are replayed to the UART transmitter on a key press, on a periodic tick, or as a sequenced loop over all frames. It sits between the UART rx/tx cores, the key debouncer and the DPRAM, and supersedes the fixed 97-byte, 1 s controller.

---
 rtl/replay_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/replay_ctrl.sv
// Record/playback controller: stores UART rx bytes into framed DPRAM and replays frames to tx.
// Optional `REPLAY_ABORT_KEY_EN: a key press while loading/sending aborts the replay.
module replay_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int FRAME_LEN  = 96,
    parameter int NUM_FRAMES = 4,
    parameter int FIDX_W     = 2,
    parameter int PERIOD_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_flag,
    input  logic              key_state,
    input  logic [1:0]        mode,
    input  logic [FIDX_W-1:0] frame_sel,
    input  logic              rx_done,
    input  logic              tx_done,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic              send_en,
    output logic              busy,
    output logic              frame_done,
    output logic              led,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    localparam logic [ADDR_W-1:0] ADDRA_LAST  = ADDR_W'(NUM_FRAMES * FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] FRAME_LEN_A = ADDR_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  TX_LAST     = CNT_W'(FRAME_LEN - 1);
    localparam logic [PER_W-1:0]  PER_LAST    = PER_W'(PERIOD_CYC - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addrA_q, addrA_d;
    logic [ADDR_W-1:0]   addrB_q, addrB_d;
    logic [CNT_W-1:0]    txCnt_q, txCnt_d;
    logic [PER_W-1:0]    perCnt_q, perCnt_d;
    logic [FIDX_W-1:0]   fidx_q, fidx_d;
    logic [1:0]          modeLat_q, modeLat_d;
    logic                armed_q, armed_d;
    logic                sendEn_q, sendEn_d;
    logic                frameDone_q, frameDone_d;
    logic                led_q, led_d;
    logic                overrun_q, overrun_d;

    logic                keyPress;
    logic                tick;
    logic                inIdle;
    logic                keyTrig;
    logic                trigger;
    logic                abortReq;
    logic [FIDX_W-1:0]   fselSafe;
    logic [ADDR_W-1:0]   frameBase;

    // State register; every register returns to its reset value on a synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addrA_q     <= '0;
            addrB_q     <= '0;
            txCnt_q     <= '0;
            perCnt_q    <= '0;
            fidx_q      <= '0;
            modeLat_q   <= '0;
            armed_q     <= 1'b0;
            sendEn_q    <= 1'b0;
            frameDone_q <= 1'b0;
            led_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addrA_q     <= addrA_d;
            addrB_q     <= addrB_d;
            txCnt_q     <= txCnt_d;
            perCnt_q    <= perCnt_d;
            fidx_q      <= fidx_d;
            modeLat_q   <= modeLat_d;
            armed_q     <= armed_d;
            sendEn_q    <= sendEn_d;
            frameDone_q <= frameDone_d;
            led_q       <= led_d;
            overrun_q   <= overrun_d;
        end
    end

    // Periodic mode: the key only arms the tick source, the tick then fires each frame.
    always_comb begin
        keyPress  = key_flag && !key_state;
        inIdle    = (state_q == IDLE);
        tick      = armed_q && (perCnt_q == PER_LAST);
        keyTrig   = keyPress && !(inIdle && (mode == 2'd1));
        trigger   = keyTrig || tick;
`ifdef REPLAY_ABORT_KEY_EN
        abortReq  = keyPress && !inIdle;
`else
        abortReq  = 1'b0;
`endif
        fselSafe  = (32'(frame_sel) >= NUM_FRAMES) ? '0 : frame_sel;
        frameBase = ADDR_W'(fidx_q) * FRAME_LEN_A;
    end

    always_comb begin
        state_d     = state_q;
        addrA_d     = addrA_q;
        addrB_d     = addrB_q;
        txCnt_d     = txCnt_q;
        perCnt_d    = perCnt_q;
        fidx_d      = fidx_q;
        modeLat_d   = modeLat_q;
        armed_d     = armed_q;
        sendEn_d    = (state_q == SEND);
        frameDone_d = 1'b0;
        led_d       = led_q ^ tick;
        overrun_d   = overrun_q;

        if (rx_done) begin
            addrA_d = (addrA_q == ADDRA_LAST) ? '0 : addrA_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (mode != 2'd1) begin
                    armed_d = 1'b0;
                end else if (keyPress) begin
                    armed_d = 1'b1;
                end
                if (trigger) begin
                    state_d   = LOAD;
                    fidx_d    = fselSafe;
                    modeLat_d = mode;
                end
            end
            LOAD: begin
                if (abortReq) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else begin
                    if (trigger) begin
                        overrun_d = 1'b1;
                    end
                    addrB_d = frameBase;
                    txCnt_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abortReq) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else begin
                    if (trigger) begin
                        overrun_d = 1'b1;
                    end
                    if (tx_done) begin
                        addrB_d = addrB_q + 1'b1;
                        txCnt_d = txCnt_q + 1'b1;
                        if (txCnt_q == TX_LAST) begin
                            frameDone_d = 1'b1;
                            if ((modeLat_q == 2'd2) && (32'(fidx_q) < NUM_FRAMES - 1)) begin
                                fidx_d  = fidx_q + 1'b1;
                                state_d = LOAD;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The counter restarts from zero on every fresh arming.
        if (armed_q && armed_d) begin
            perCnt_d = tick ? '0 : perCnt_q + 1'b1;
        end else begin
            perCnt_d = '0;
        end
    end

    assign wea        = rx_done;
    assign addra      = addrA_q;
    assign addrb      = addrB_q;
    assign send_en    = sendEn_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frameDone_q;
    assign led        = led_q;
    assign overrun    = overrun_q;

endmodule
